lpc_periph_multi: RTL and testbench

Parametrised LPC peripheral target that decodes I/O and memory cycles against `NUM_WIN` configurable address windows. It serialises LAD nibbles into a held back-end request with a done handshake. It also inserts long-wait SYNCs while the back-end is busy and issues an error SYNC on timeout. It replaces the single-window peripheral behind the LPC host in the system, with the LAD tri-state pad kept outside the block.

---
 rtl/lpc_pkg.sv | 9 +
 rtl/lpc_win_decode.sv | 19 +
 rtl/lpc_periph_multi.sv | 182 ++++++++++++++++++
 tb/tb_lpc_periph_multi.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// lpc_pkg: shared LPC cycle-type codes, SYNC codes and target state encoding.
package lpc_pkg;
  localparam logic [1:0] CT_IO = 2'b00;
  localparam logic [1:0] CT_MEM = 2'b01;
  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_LWAIT = 4'h6;
  localparam logic [3:0] SYNC_ERR = 4'hA;
  typedef enum logic [2:0] {IDLE, CYC, ADDR, WDAT, HTAR, SYNC, RDAT, PTAR} state_e;
endpackage

// File: rtl/lpc_win_decode.sv
// lpc_win_decode: masked address compare against NUM_WIN windows, lowest index wins (one-hot).
module lpc_win_decode #(
  parameter int NUM_WIN = 2,
  parameter logic [NUM_WIN*32-1:0] WIN_BASE = '0,
  parameter logic [NUM_WIN*32-1:0] WIN_MASK = '1,
  parameter logic [NUM_WIN-1:0] WIN_MEM = '0
) (
  input  logic [31:0]        addr_i,
  input  logic               mem_i,
  output logic [NUM_WIN-1:0] win_o
);
  logic [NUM_WIN-1:0] hit;
  for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
    assign hit[k] = ((addr_i & WIN_MASK[32*k+:32]) == (WIN_BASE[32*k+:32] & WIN_MASK[32*k+:32]))
                    && (WIN_MEM[k] == mem_i);
  end
  // Isolate the lowest set bit.
  assign win_o = hit & (-hit);
endmodule

// File: rtl/lpc_periph_multi.sv
// lpc_periph_multi: multi-window LPC I/O/memory target with held back-end request,
// long-wait SYNC insertion and error SYNC on back-end timeout.
module lpc_periph_multi
  import lpc_pkg::*;
#(
  parameter int NUM_WIN = 2,
  parameter logic [NUM_WIN*32-1:0] WIN_BASE = '0,
  parameter logic [NUM_WIN*32-1:0] WIN_MASK = '1,
  parameter logic [NUM_WIN-1:0] WIN_MEM = '0,
  parameter int MAX_WAIT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lframe_i,
  input  logic [3:0]         lad_i,
  output logic [3:0]         lad_o,
  output logic               lad_oe,
  output logic [31:0]        addr_o,
  output logic [7:0]         data_o,
  output logic [NUM_WIN-1:0] win_o,
  output logic               mem_o,
  output logic               wr_o,
  output logic               rd_o,
  input  logic               done_i,
  input  logic [7:0]         data_i,
  output logic               timeout_o
);
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic mem_q, mem_d, is_wr_q, is_wr_d;
  logic [31:0] addr_q, addr_d, addr_shift;
  logic [7:0] data_q, data_d, rdata_q, rdata_d;
  logic [NUM_WIN-1:0] win_q, win_d, hit;
  logic wr_q, wr_d, rd_q, rd_d, tmo_q, tmo_d, oe_q, oe_d;
  logic [3:0] lad_q, lad_d;
  assign addr_shift = {addr_q[27:0], lad_i};
  lpc_win_decode #(
    .NUM_WIN (NUM_WIN),
    .WIN_BASE(WIN_BASE),
    .WIN_MASK(WIN_MASK),
    .WIN_MEM (WIN_MEM)
  ) u_dec (
    .addr_i(addr_shift),
    .mem_i (mem_q),
    .win_o (hit)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wcnt_d = wcnt_q;
    mem_d = mem_q;
    is_wr_d = is_wr_q;
    addr_d = addr_q;
    data_d = data_q;
    rdata_d = rdata_q;
    win_d = win_q;
    wr_d = wr_q;
    rd_d = rd_q;
    tmo_d = 1'b0;
    oe_d = oe_q;
    lad_d = lad_q;
    if (!lframe_i) begin
      state_d = (lad_i == 4'h0) ? CYC : IDLE;
      wr_d = 1'b0;
      rd_d = 1'b0;
      oe_d = 1'b0;
      lad_d = 4'hF;
    end else begin
      case (state_q)
        CYC: begin
          mem_d = lad_i[3:2] == CT_MEM;
          is_wr_d = lad_i[1];
          addr_d = '0;
          cnt_d = '0;
          state_d = (lad_i[3:2] == CT_IO || lad_i[3:2] == CT_MEM) ? ADDR : IDLE;
        end
        ADDR: begin
          addr_d = addr_shift;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == (mem_q ? 3'd7 : 3'd3)) begin
            win_d = hit;
            cnt_d = '0;
            state_d = (|hit) ? (is_wr_q ? WDAT : HTAR) : IDLE;
          end
        end
        WDAT: begin
          data_d = cnt_q[0] ? {lad_i, data_q[3:0]} : {data_q[7:4], lad_i};
          cnt_d = cnt_q[0] ? 3'd0 : 3'd1;
          state_d = cnt_q[0] ? HTAR : WDAT;
        end
        HTAR: begin
          cnt_d = 3'd1;
          if (cnt_q[0]) begin
            state_d = SYNC;
            wr_d = is_wr_q;
            rd_d = !is_wr_q;
            lad_d = SYNC_LWAIT;
            oe_d = 1'b1;
            wcnt_d = '0;
          end
        end
        SYNC: begin
          // With the request still high we are waiting; once dropped, this is the final SYNC cycle.
          if (wr_q || rd_q) begin
            if (done_i) begin
              lad_d = SYNC_READY;
              wr_d = 1'b0;
              rd_d = 1'b0;
              rdata_d = data_i;
            end else if (wcnt_q == 8'(MAX_WAIT - 1)) begin
              lad_d = SYNC_ERR;
              wr_d = 1'b0;
              rd_d = 1'b0;
              tmo_d = 1'b1;
              rdata_d = 8'hFF;
            end else begin
              wcnt_d = wcnt_q + 8'd1;
            end
          end else begin
            state_d = is_wr_q ? PTAR : RDAT;
            lad_d = is_wr_q ? 4'hF : rdata_q[3:0];
            cnt_d = '0;
          end
        end
        RDAT: begin
          lad_d = cnt_q[0] ? 4'hF : rdata_q[7:4];
          cnt_d = 3'd1;
          state_d = cnt_q[0] ? PTAR : RDAT;
        end
        PTAR: begin
          state_d = IDLE;
          oe_d = 1'b0;
          lad_d = 4'hF;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wcnt_q <= '0;
      mem_q <= 1'b0;
      is_wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      win_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      tmo_q <= 1'b0;
      oe_q <= 1'b0;
      lad_q <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wcnt_q <= wcnt_d;
      mem_q <= mem_d;
      is_wr_q <= is_wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rdata_q <= rdata_d;
      win_q <= win_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      tmo_q <= tmo_d;
      oe_q <= oe_d;
      lad_q <= lad_d;
    end
  end
  assign lad_o = lad_q;
  assign lad_oe = oe_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign win_o = win_q;
  assign mem_o = mem_q;
  assign wr_o = wr_q;
  assign rd_o = rd_q;
  assign timeout_o = tmo_q;
endmodule

// File: tb/tb_lpc_periph_multi.sv
// tb_lpc_periph_multi: transaction-level LPC model (cycle timeline from the protocol rules)
// checked against the DUT every cycle, with directed cases and randomized traffic.
module tb_lpc_periph_multi;
  localparam int NW = 4;
  localparam int MW = 4;
  localparam logic [NW*32-1:0] BASE = {32'h0000_0020, 32'h0000_002E, 32'hFED4_0000, 32'h0000_0080};
  localparam logic [NW*32-1:0] MASK = {32'h0000_FFF0, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF};
  localparam logic [NW-1:0] WMEM = 4'b0010;
  // The same windows written as inclusive address ranges.
  localparam logic [31:0] LO [NW] = '{32'h80, 32'hFED4_0000, 32'h2E, 32'h20};
  localparam logic [31:0] HI [NW] = '{32'h80, 32'hFED4_FFFF, 32'h2E, 32'h2F};
  localparam bit RMEM [NW] = '{0, 1, 0, 0};

  logic clk_i = 0, rst_i = 1, lframe_i = 1, done_i = 0;
  logic [3:0] lad_i = 4'hF, lad_o;
  logic [7:0] data_i = 0, data_o;
  logic [31:0] addr_o;
  logic [NW-1:0] win_o;
  logic lad_oe, mem_o, wr_o, rd_o, timeout_o;
  int checks = 0, errors = 0;
  bit late_done = 0;
  logic e_chk = 0, e_oe = 0, e_wr = 0, e_rd = 0, e_tmo = 0, e_rst = 0, e_mem = 0;
  logic [3:0] e_lad = 4'hF, e_win = 0;
  logic [31:0] e_addr = 0;
  logic [7:0] e_data = 0;
  logic [3:0] lad_log[$];

  lpc_periph_multi #(
    .NUM_WIN(NW), .WIN_BASE(BASE), .WIN_MASK(MASK), .WIN_MEM(WMEM), .MAX_WAIT(MW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .lframe_i(lframe_i), .lad_i(lad_i), .lad_o(lad_o),
    .lad_oe(lad_oe), .addr_o(addr_o), .data_o(data_o), .win_o(win_o), .mem_o(mem_o),
    .wr_o(wr_o), .rd_o(rd_o), .done_i(done_i), .data_i(data_i), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [3:0] win_model(input logic [31:0] a, input bit m);
    for (int k = 0; k < NW; k++)
      if (a >= LO[k] && a <= HI[k] && m == RMEM[k]) return 4'(1 << k);
    return 4'h0;
  endfunction

  always @(negedge clk_i) begin
    if (e_chk) begin
      chk("lad_oe", 32'(lad_oe), 32'(e_oe));
      if (e_oe || e_rst) chk("lad_o", 32'(lad_o), 32'(e_lad));
      chk("wr_o", 32'(wr_o), 32'(e_wr));
      chk("rd_o", 32'(rd_o), 32'(e_rd));
      chk("timeout_o", 32'(timeout_o), 32'(e_tmo));
      if (e_wr || e_rd || e_rst) begin
        chk("addr_o", addr_o, e_addr);
        chk("win_o", 32'(win_o), 32'(e_win));
        chk("mem_o", 32'(mem_o), 32'(e_mem));
      end
      if (e_wr || e_rst) chk("data_o", 32'(data_o), 32'(e_data));
      if (lad_oe) lad_log.push_back(lad_o);
    end
  end

  task automatic idle(input int n, input bit rchk);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      rst_i = 0; lframe_i = 1; lad_i = 4'hF; done_i = 0;
      e_oe = 0; e_wr = 0; e_rd = 0; e_tmo = 0; e_rst = rchk;
      e_lad = 4'hF; e_addr = 0; e_data = 0; e_win = 0; e_mem = 0;
    end
  endtask

  // One LPC cycle from START (c = 0). cut >= 0 stops at that cycle with a new START
  // (mode 1) or a reset pulse (mode 2); restart skips the START already driven.
  task automatic txn(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] wd,
                     input logic [7:0] rdv, input int d, input int cut, input int mode,
                     input bit restart);
    bit mem, wr, claim, ok;
    int nad, sync0, nw, se, len;
    logic [31:0] ae;
    logic [3:0] w;
    logic [7:0] rdat;
    mem = ct[2];
    wr = ct[1];
    nad = mem ? 8 : 4;
    ae = mem ? a : {16'h0, a[15:0]};
    w = win_model(ae, mem);
    claim = !ct[3] && w != 0;
    sync0 = 4 + nad + (wr ? 2 : 0);
    ok = d < MW;
    nw = ok ? d + 1 : MW;
    se = sync0 + nw;
    rdat = ok ? rdv : 8'hFF;
    len = claim ? se + (wr ? 3 : 5) : sync0 + 3;
    for (int c = restart ? 1 : 0; c < len; c++) begin
      @(posedge clk_i); #1;
      rst_i = c == cut && mode == 2;
      lframe_i = !(c == 0 || (c == cut && mode == 1));
      if (!lframe_i) lad_i = 4'h0;
      else if (c == 1) lad_i = ct;
      else if (c < 2 + nad) lad_i = 4'(ae >> (4 * (nad + 1 - c)));
      else if (wr && c == 2 + nad) lad_i = wd[3:0];
      else if (wr && c == 3 + nad) lad_i = wd[7:4];
      else lad_i = 4'hF;
      done_i = (claim && ok && c == sync0 + d) || (late_done && c == 1);
      data_i = rdv;
      e_oe = claim && c >= sync0 && c < se + (wr ? 2 : 4);
      if (c < se) e_lad = 4'h6;
      else if (c == se) e_lad = ok ? 4'h0 : 4'hA;
      else if (!wr && c == se + 1) e_lad = rdat[3:0];
      else if (!wr && c == se + 2) e_lad = rdat[7:4];
      else e_lad = 4'hF;
      e_wr = claim && wr && c >= sync0 && c < se;
      e_rd = claim && !wr && c >= sync0 && c < se;
      e_tmo = claim && !ok && c == se;
      e_addr = ae; e_data = wd; e_win = w; e_mem = mem; e_rst = 0;
      if (c == cut) break;
    end
    late_done = 0;
  endtask

  task automatic log_chk(input string n, input logic [3:0] exp[$]);
    chk({n, "_len"}, 32'(lad_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < lad_log.size(); i++) chk(n, 32'(lad_log[i]), 32'(exp[i]));
    lad_log.delete();
  endtask

  initial begin
    logic [3:0] ct;
    logic [31:0] a;
    int sel;
    repeat (3) @(posedge clk_i);
    e_chk = 1;
    idle(2, 1);
    chk("pin_win_80", 32'(win_model(32'h80, 0)), 32'h1);
    chk("pin_win_mem", 32'(win_model(32'hFED4_0000, 1)), 32'h2);
    chk("pin_win_2e", 32'(win_model(32'h2E, 0)), 32'h4);
    chk("pin_win_81", 32'(win_model(32'h81, 0)), 32'h0);
    lad_log.delete();
    txn(4'h2, 32'h80, 8'h5A, 8'h00, 2, -1, 0, 0);
    log_chk("io_wr_lad", '{4'h6, 4'h6, 4'h6, 4'h0, 4'hF});
    idle(1, 0);
    txn(4'h4, 32'hFED4_0000, 8'h00, 8'hA5, 0, -1, 0, 0);
    log_chk("mem_rd_lad", '{4'h6, 4'h0, 4'h5, 4'hA, 4'hF});
    txn(4'h0, 32'h81, 8'h00, 8'h11, 0, -1, 0, 0);
    log_chk("nohit_lad", '{});
    txn(4'h0, 32'h80, 8'h00, 8'h33, 99, -1, 0, 0);
    log_chk("tmo_lad", '{4'h6, 4'h6, 4'h6, 4'h6, 4'hA, 4'hF, 4'hF, 4'hF});
    txn(4'h0, 32'h80, 8'h00, 8'h3C, MW - 1, -1, 0, 0);
    log_chk("tie_lad", '{4'h6, 4'h6, 4'h6, 4'h6, 4'h0, 4'hC, 4'h3, 4'hF});
    txn(4'h0, 32'h80, 8'h00, 8'h77, 99, 9, 1, 0);
    late_done = 1;
    txn(4'h2, 32'h2E, 8'hC3, 8'h00, 1, -1, 0, 1);
    txn(4'h2, 32'h25, 8'h96, 8'h00, 0, 6, 2, 0);
    idle(2, 1);
    lad_log.delete();
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      ct = sel < 8 ? (4'(2 * (sel % 4)) | 4'($urandom_range(0, 1))) : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 6))
        0: a = 32'h80;
        1: a = 32'h81;
        2: a = 32'h2E;
        3: a = 32'h20 | 32'($urandom_range(0, 15));
        4: a = 32'hFED4_0000 | 32'($urandom_range(0, 65535));
        5: a = 32'hFED5_0000;
        default: a = $urandom;
      endcase
      txn(ct, a, 8'($urandom), 8'($urandom), $urandom_range(0, MW + 2), -1, 0, 0);
      idle($urandom_range(0, 2), 0);
    end
    idle(2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
